// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer for a pipeline boundary.
// The head ("main") entry drives the outputs. The "skid" entry catches one
// upstream beat that arrives while the head is stalled, so in_ready can be
// computed purely from registered state (no out_ready -> in_ready path).
// A flush empties the stage and loads the incoming tag into the head tag,
// so flow tracking stays correct across the discard.
module pipe_skid_stage #(
    parameter int DATA_W      = 160,
    parameter int TAG_W       = 32,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              flush,
    input  logic              hold_in,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as the entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0]  main_tag_q,  main_tag_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0]  skid_tag_q,  skid_tag_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              in_fire;
    logic              out_fire;
    logic              stalled;
    logic [DATA_W-1:0] drain_data;

    // Handshake: acceptance depends only on registered state and the
    // upstream-side controls; reset, flush and hazard hold all refuse entry.
    assign in_ready  = !rst && !flush && !hold_in && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign stalled   = out_valid && !out_ready;
    assign occupancy = state_q;
    assign out_tag   = main_tag_q;
    assign stall_cnt = stall_cnt_q;

    // Payload value written into the head when the stage empties: zero when
    // bubbles must read as zero, otherwise the stale payload is simply kept.
    generate
        if (ZERO_BUBBLE != 0) begin : g_zero_bubble
            assign drain_data = '0;
            assign out_data   = out_valid ? main_data_q : '0;
        end else begin : g_keep_bubble
            assign drain_data = main_data_q;
            assign out_data   = main_data_q;
        end
    endgenerate

    // Next-state and entry movement; flush overrides every other event.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = drain_data;
            main_tag_d  = in_tag;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_tag_d  = in_tag;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Head leaves and the new beat replaces it directly.
                        main_data_d = in_data;
                        main_tag_d  = in_tag;
                    end else if (in_fire) begin
                        // Head is stalled: park the new beat behind it.
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_tag_d  = in_tag;
                    end else if (out_fire) begin
                        // Drain to empty; tag is kept for flow tracking.
                        state_d     = ST_EMPTY;
                        main_data_d = drain_data;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_tag_d  = skid_tag_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Stall counter: counts presented-but-not-consumed cycles, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenarios followed by randomized
// traffic. The stimulus process pushes each accepted beat into a scoreboard
// queue; a monitor on the falling edge compares every DUT output against
// that FIFO model and pops on each downstream consume.
module tb_pipe_skid_stage;

    localparam int DATA_W = 160;
    localparam int TAG_W  = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              flush = 1'b0;
    logic              hold_in = 1'b0;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            sb_q[$];
    int                checks = 0;
    int                failures = 0;
    bit                mon_en = 1'b0;
    bit                exp_in_ready = 1'b0;
    logic [CNT_W-1:0]  exp_stall = '0;
    logic [TAG_W-1:0]  last_tag = '0;
    bit                last_acc;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W(DATA_W),
        .TAG_W(TAG_W),
        .ZERO_BUBBLE(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag),
        .flush(flush),
        .hold_in(hold_in),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i += 32) d[i +: 32] = $urandom();
        return d;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. The acceptance decision comes from the model:
    // the stage takes a beat whenever it is not full and not blocked.
    task automatic cyc(input bit r, input bit f, input bit h, input bit v,
                       input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                       input bit ordy, output bit acc);
        entry_t e;
        @(posedge clk);
        #1;
        rst = r; flush = f; hold_in = h; in_valid = v;
        in_data = d; in_tag = t; out_ready = ordy;
        exp_in_ready = !r && !f && !h && (sb_q.size() < 2);
        acc = exp_in_ready && v;
        mon_en = 1'b1;
        #5;
        if (r || f) begin
            sb_q.delete();
        end else if (acc) begin
            e.data = d;
            e.tag  = t;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(0, 0, 0, 0, '0, '0, ordy, last_acc);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, '0, '0, 0, last_acc);
    endtask

    // Monitor: compare outputs against the model, then advance the model's
    // view of the downstream side for the coming edge.
    initial begin
        entry_t head;
        int     n;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n = sb_q.size();
                check("in_ready", in_ready, exp_in_ready);
                check("out_valid", out_valid, n != 0);
                check("occupancy", occupancy, n);
                check("stall_cnt", stall_cnt, exp_stall);
                if (n != 0) begin
                    check("out_data", out_data, sb_q[0].data);
                    check("out_tag", out_tag, sb_q[0].tag);
                end else begin
                    check("bubble_data", out_data, '0);
                    check("held_tag", out_tag, last_tag);
                end
                if (rst) begin
                    exp_stall = '0;
                    last_tag  = '0;
                end else begin
                    if (n != 0 && !out_ready && exp_stall != {CNT_W{1'b1}})
                        exp_stall = exp_stall + 1'b1;
                    if (n != 0 && out_ready) begin
                        head = sb_q.pop_front();
                        last_tag = head.tag;
                    end
                    if (flush) last_tag = in_tag;
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] a5;
        bit acc;
        int guard;
        a5 = '0;
        a5[7:0] = 8'hA5;

        do_reset();
        do_reset();

        // Single beat straight through with downstream ready.
        cyc(0, 0, 0, 1, a5, 32'h11, 1, acc);
        idle(1);
        idle(1);

        // Fill while stalled, third beat held upstream, then drain in order.
        do_reset();
        cyc(0, 0, 0, 1, rand_data(), 32'hA, 0, acc);
        cyc(0, 0, 0, 1, rand_data(), 32'hB, 0, acc);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, {5{32'hCCCC0000}}, 32'hC, 0, acc);
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 10) begin
            cyc(0, 0, 0, 1, {5{32'hCCCC0000}}, 32'hC, 1, acc);
            guard++;
        end
        check("c_accepted", acc, 1'b1);
        for (int i = 0; i < 3; i++) idle(1);

        // Flush while full with a concurrent upstream tag.
        cyc(0, 0, 0, 1, rand_data(), 32'h21, 0, acc);
        cyc(0, 0, 0, 1, rand_data(), 32'h22, 0, acc);
        cyc(0, 1, 0, 1, rand_data(), 32'h100, 0, acc);
        idle(0);
        idle(1);

        // Hazard hold: head drains, bubble appears, beat enters after release.
        cyc(0, 0, 0, 1, rand_data(), 32'h31, 0, acc);
        cyc(0, 0, 1, 1, {5{32'hDDDD0001}}, 32'h32, 1, acc);
        cyc(0, 0, 1, 1, {5{32'hDDDD0001}}, 32'h32, 1, acc);
        cyc(0, 0, 0, 1, {5{32'hDDDD0001}}, 32'h32, 1, acc);
        check("hold_release_accept", acc, 1'b1);
        idle(1);

        // Stall counter saturation over a long stall.
        do_reset();
        cyc(0, 0, 0, 1, rand_data(), 32'h41, 0, acc);
        for (int i = 0; i < 20; i++) idle(0);
        idle(1);

        // Reset in the middle of a full, stalled stage.
        cyc(0, 0, 0, 1, rand_data(), 32'h51, 0, acc);
        cyc(0, 0, 0, 1, rand_data(), 32'h52, 0, acc);
        cyc(1, 0, 0, 1, rand_data(), 32'h53, 0, acc);
        idle(0);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) < 7,
                rand_data(),
                $urandom(),
                $urandom_range(0, 9) < 6,
                acc);
        end
        idle(1);
        idle(1);
        idle(1);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
